// File: rtl/enc_prio_rr.sv
// Registered N-to-log2(N) request encoder with fixed-priority or round-robin
// arbitration, a multi-request flag and a one-entry valid/ready output stage.
module enc_prio_rr #(
    parameter  int unsigned N  = 8,
    parameter  int unsigned RR = 0,
    localparam int unsigned W  = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_n,
    input  logic [N-1:0] req,
    output logic [W-1:0] y,
    output logic         valid,
    output logic         multi,
    input  logic         out_ready
);

    logic [W-1:0] ptr;
    logic [W-1:0] ptr_nxt;
    logic [W-1:0] win;
    logic         found;
    logic         any;
    logic         many;
    logic         load;
    int unsigned  j;

    assign any  = |req;
    assign many = (req & (req - N'(1))) != '0;
    assign load = !en_n && (!valid || out_ready);

    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        if (RR == 0) begin
            // ascending scan: the last (highest) set index wins
            for (int unsigned i = 0; i < N; i++) begin
                if (req[i]) win = W'(i);
            end
        end else begin
            // scan starting at ptr, wrapping at N rather than 2**W
            for (int unsigned k = 0; k < N; k++) begin
                j = 32'(ptr) + k;
                if (j >= N) j = j - N;
                if (!found && req[j]) begin
                    win   = W'(j);
                    found = 1'b1;
                end
            end
        end
        ptr_nxt = (win == W'(N - 1)) ? '0 : win + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y     <= '0;
            valid <= 1'b0;
            multi <= 1'b0;
            ptr   <= '0;
        end else if (load) begin
            if (any) begin
                y     <= win;
                valid <= 1'b1;
                multi <= many;
                if (RR != 0) ptr <= ptr_nxt;
            end else begin
                y     <= '0;
                valid <= 1'b0;
                multi <= 1'b0;
            end
        end else if (valid && out_ready) begin
            y     <= '0;
            valid <= 1'b0;
            multi <= 1'b0;
        end
    end

endmodule

// File: tb/tb_enc_prio_rr.sv
// Directed bench for enc_prio_rr: fixed priority (N=8), round-robin (N=8)
// and round-robin with a non-power-of-two width (N=5).
module tb_enc_prio_rr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       f_en, f_rdy, f_v, f_m;
    logic [7:0] f_req;
    logic [2:0] f_y;
    logic       r_en, r_rdy, r_v, r_m;
    logic [7:0] r_req;
    logic [2:0] r_y;
    logic       n_en, n_rdy, n_v, n_m;
    logic [4:0] n_req;
    logic [2:0] n_y;

    int total = 0;
    int bad   = 0;

    enc_prio_rr #(.N(8), .RR(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .en_n(f_en), .req(f_req),
        .y(f_y), .valid(f_v), .multi(f_m), .out_ready(f_rdy));

    enc_prio_rr #(.N(8), .RR(1)) u_rr8 (
        .clk(clk), .rst_n(rst_n), .en_n(r_en), .req(r_req),
        .y(r_y), .valid(r_v), .multi(r_m), .out_ready(r_rdy));

    enc_prio_rr #(.N(5), .RR(1)) u_rr5 (
        .clk(clk), .rst_n(rst_n), .en_n(n_en), .req(n_req),
        .y(n_y), .valid(n_v), .multi(n_m), .out_ready(n_rdy));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        f_en = 1'b1; f_rdy = 1'b1; f_req = '0;
        r_en = 1'b1; r_rdy = 1'b1; r_req = '0;
        n_en = 1'b1; n_rdy = 1'b1; n_req = '0;
        #12;
        total++;
        if ({f_v, f_y, f_m} !== 5'b0_000_0) begin
            bad++; $display("FAIL reset_fix got v/y/m=%b/%0d/%b want 0/0/0", f_v, f_y, f_m);
        end
        total++;
        if ({r_v, r_y, r_m} !== 5'b0_000_0) begin
            bad++; $display("FAIL reset_rr8 got v/y/m=%b/%0d/%b want 0/0/0", r_v, r_y, r_m);
        end
        total++;
        if ({n_v, n_y, n_m} !== 5'b0_000_0) begin
            bad++; $display("FAIL reset_rr5 got v/y/m=%b/%0d/%b want 0/0/0", n_v, n_y, n_m);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fixed_basic;
        f_en = 1'b0; f_rdy = 1'b1; f_req = 8'b1001_0000;
        tick;
        total++;
        if ({f_v, f_y, f_m} !== {1'b1, 3'd7, 1'b1}) begin
            bad++; $display("FAIL fix_multi got v/y/m=%b/%0d/%b want 1/7/1", f_v, f_y, f_m);
        end
        f_req = 8'h01;
        tick;
        total++;
        if ({f_v, f_y, f_m} !== {1'b1, 3'd0, 1'b0}) begin
            bad++; $display("FAIL fix_single got v/y/m=%b/%0d/%b want 1/0/0", f_v, f_y, f_m);
        end
    endtask

    task automatic test_fixed_sweep;
        logic [2:0] e;
        for (int i = 0; i < 8; i++) begin
            f_req = 8'h01 << i;
            e = 3'(i);
            tick;
            total++;
            if ({f_v, f_y, f_m} !== {1'b1, e, 1'b0}) begin
                bad++; $display("FAIL fix_sweep[%0d] got v/y/m=%b/%0d/%b want 1/%0d/0", i, f_v, f_y, f_m, e);
            end
        end
        f_en = 1'b1;
        tick;
        total++;
        if ({f_v, f_y, f_m} !== 5'b0_000_0) begin
            bad++; $display("FAIL fix_drain got v/y/m=%b/%0d/%b want 0/0/0", f_v, f_y, f_m);
        end
        for (int i = 0; i < 8; i++) begin
            f_req = 8'h01 << i;
            tick;
            total++;
            if ({f_v, f_y, f_m} !== 5'b0_000_0) begin
                bad++; $display("FAIL fix_disabled[%0d] got v/y/m=%b/%0d/%b want 0/0/0", i, f_v, f_y, f_m);
            end
        end
    endtask

    task automatic test_stall;
        f_en = 1'b0; f_rdy = 1'b0; f_req = 8'h20;
        tick;
        total++;
        if ({f_v, f_y, f_m} !== {1'b1, 3'd5, 1'b0}) begin
            bad++; $display("FAIL stall_grant got v/y/m=%b/%0d/%b want 1/5/0", f_v, f_y, f_m);
        end
        f_req = 8'h02;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if ({f_v, f_y, f_m} !== {1'b1, 3'd5, 1'b0}) begin
                bad++; $display("FAIL stall_hold[%0d] got v/y/m=%b/%0d/%b want 1/5/0", i, f_v, f_y, f_m);
            end
        end
        f_rdy = 1'b1;
        tick;
        total++;
        if ({f_v, f_y, f_m} !== {1'b1, 3'd1, 1'b0}) begin
            bad++; $display("FAIL stall_release got v/y/m=%b/%0d/%b want 1/1/0", f_v, f_y, f_m);
        end
    endtask

    task automatic test_enable_and_empty;
        f_req = 8'hC0; f_rdy = 1'b0; f_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick;
            total++;
            if ({f_v, f_y, f_m} !== {1'b1, 3'd1, 1'b0}) begin
                bad++; $display("FAIL en_hold[%0d] got v/y/m=%b/%0d/%b want 1/1/0", i, f_v, f_y, f_m);
            end
        end
        f_rdy = 1'b1;
        tick;
        total++;
        if ({f_v, f_y, f_m} !== 5'b0_000_0) begin
            bad++; $display("FAIL en_drain got v/y/m=%b/%0d/%b want 0/0/0", f_v, f_y, f_m);
        end
        f_en = 1'b0;
        tick;
        total++;
        if ({f_v, f_y, f_m} !== {1'b1, 3'd7, 1'b1}) begin
            bad++; $display("FAIL reload got v/y/m=%b/%0d/%b want 1/7/1", f_v, f_y, f_m);
        end
        f_req = '0;
        tick;
        total++;
        if ({f_v, f_y, f_m} !== 5'b0_000_0) begin
            bad++; $display("FAIL empty_sample got v/y/m=%b/%0d/%b want 0/0/0", f_v, f_y, f_m);
        end
        f_en = 1'b1;
    endtask

    task automatic test_rr_all;
        logic [2:0] e;
        logic [2:0] alt [4] = '{3'd2, 3'd5, 3'd2, 3'd5};
        r_en = 1'b0; r_rdy = 1'b1; r_req = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            e = 3'(k % 8);
            tick;
            total++;
            if ({r_v, r_y, r_m} !== {1'b1, e, 1'b1}) begin
                bad++; $display("FAIL rr8_all[%0d] got v/y/m=%b/%0d/%b want 1/%0d/1", k, r_v, r_y, r_m, e);
            end
        end
        r_req = 8'b0010_0100;
        for (int k = 0; k < 4; k++) begin
            tick;
            total++;
            if ({r_v, r_y, r_m} !== {1'b1, alt[k], 1'b1}) begin
                bad++; $display("FAIL rr8_alt[%0d] got v/y/m=%b/%0d/%b want 1/%0d/1", k, r_v, r_y, r_m, alt[k]);
            end
        end
    endtask

    task automatic test_rr_n5;
        logic [2:0] e;
        n_en = 1'b0; n_rdy = 1'b1; n_req = 5'b10001;
        for (int k = 0; k < 4; k++) begin
            e = (k % 2 == 0) ? 3'd0 : 3'd4;
            tick;
            total++;
            if ({n_v, n_y, n_m} !== {1'b1, e, 1'b1}) begin
                bad++; $display("FAIL rr5_pair[%0d] got v/y/m=%b/%0d/%b want 1/%0d/1", k, n_v, n_y, n_m, e);
            end
        end
        n_rdy = 1'b0; n_req = 5'b00100;
        tick;
        total++;
        if ({n_v, n_y, n_m} !== {1'b1, 3'd4, 1'b1}) begin
            bad++; $display("FAIL rr5_stall got v/y/m=%b/%0d/%b want 1/4/1", n_v, n_y, n_m);
        end
        n_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick;
            total++;
            if ({n_v, n_y, n_m} !== {1'b1, 3'd4, 1'b1}) begin
                bad++; $display("FAIL rr5_en_hold[%0d] got v/y/m=%b/%0d/%b want 1/4/1", k, n_v, n_y, n_m);
            end
        end
        n_rdy = 1'b1;
        tick;
        total++;
        if ({n_v, n_y, n_m} !== 5'b0_000_0) begin
            bad++; $display("FAIL rr5_drain got v/y/m=%b/%0d/%b want 0/0/0", n_v, n_y, n_m);
        end
        n_en = 1'b0; n_req = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            e = 3'(k % 5);
            tick;
            total++;
            if ({n_v, n_y, n_m} !== {1'b1, e, 1'b1}) begin
                bad++; $display("FAIL rr5_wrap[%0d] got v/y/m=%b/%0d/%b want 1/%0d/1", k, n_v, n_y, n_m, e);
            end
        end
        n_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        r_req = 8'h04;
        tick;
        total++;
        if ({r_v, r_y, r_m} !== {1'b1, 3'd2, 1'b0}) begin
            bad++; $display("FAIL mid_setup got v/y/m=%b/%0d/%b want 1/2/0", r_v, r_y, r_m);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({r_v, r_y, r_m} !== 5'b0_000_0) begin
            bad++; $display("FAIL mid_async_rr8 got v/y/m=%b/%0d/%b want 0/0/0", r_v, r_y, r_m);
        end
        total++;
        if ({n_v, n_y, n_m} !== 5'b0_000_0) begin
            bad++; $display("FAIL mid_async_rr5 got v/y/m=%b/%0d/%b want 0/0/0", n_v, n_y, n_m);
        end
        #1 rst_n = 1'b1;
        r_req = 8'hFF; r_en = 1'b0; r_rdy = 1'b1;
        tick;
        total++;
        if ({r_v, r_y, r_m} !== {1'b1, 3'd0, 1'b1}) begin
            bad++; $display("FAIL mid_first_grant got v/y/m=%b/%0d/%b want 1/0/1", r_v, r_y, r_m);
        end
        tick;
        total++;
        if ({r_v, r_y, r_m} !== {1'b1, 3'd1, 1'b1}) begin
            bad++; $display("FAIL mid_second_grant got v/y/m=%b/%0d/%b want 1/1/1", r_v, r_y, r_m);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_basic();
        test_fixed_sweep();
        test_stall();
        test_enable_and_empty();
        test_rr_all();
        test_rr_n5();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
